// File: rtl/ram_loader.sv
// ram_loader: host-to-RAM programmer for the SAP-style CPU.
// Host bytes are captured on a rising strobe into a small FIFO. Each data
// entry is written into RAM by sequencing MAR-address, MAR-data and RAM-write
// strobes on the shared bus. Pointer entries reload the write pointer instead.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a FIFO entry
// SETP  | load write pointer from head entry, pop
// ADDR  | drive write pointer on bus, L_MA active
// DATA  | drive head data on bus, L_MD active
// WRITE | drive head data on bus, L_R active
// ADV   | pop entry, advance pointer, flag wrap on max address
module ram_loader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              prog_en,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  input  logic              cmd_addr,
  inout  wire  [DATA_W-1:0] bus,
  output logic [14:0]       ctrl_out,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [14:0] CTRL_IDLE = 15'b000111111100011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETP  = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_ADV   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic              vld_d;
  logic [DATA_W:0]   head;
  logic              push, pop, push_ok, fifo_empty;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_drv;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign push       = byte_valid && !vld_d && prog_en;
  assign pop        = prog_en && ((state == S_SETP) || (state == S_ADV));
  // A pop on the same edge frees the slot the incoming push needs.
  assign push_ok    = push && (!fifo_full || pop);
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign bus        = (prog_en && bus_oe) ? bus_drv : {DATA_W{1'bz}};

  // FIFO storage: entry is {is_addr, byte}.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {cmd_addr, byte_in};
  end

  // FIFO pointers, occupancy, strobe edge detect and sticky overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      vld_d    <= 1'b0;
    end else begin
      vld_d <= byte_valid;
      if (!prog_en) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
        if (push && fifo_full && !pop) overflow <= 1'b1;
      end
    end
  end

  // State register, write pointer and wrap pulse.
  always_ff @(posedge clk) begin
    if (!resetn || !prog_en) begin
      state   <= S_IDLE;
      wr_addr <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == S_SETP) wr_addr <= head[ADDR_W-1:0];
      if (state == S_ADV) begin
        wr_addr <= wr_addr + 1'b1;
        done    <= (wr_addr == '1);
      end
    end
  end

  // Next state and state-decoded control word / bus drive.
  always_comb begin
    state_nxt = S_IDLE;
    ctrl_out  = CTRL_IDLE;
    bus_oe    = 1'b0;
    bus_drv   = '0;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = head[DATA_W] ? S_SETP : S_ADDR;
      S_SETP:  state_nxt = S_IDLE;
      S_ADDR: begin
        state_nxt    = S_DATA;
        ctrl_out[11] = 1'b0;
        bus_oe       = 1'b1;
        bus_drv      = DATA_W'(wr_addr);
      end
      S_DATA: begin
        state_nxt    = S_WRITE;
        ctrl_out[10] = 1'b0;
        bus_oe       = 1'b1;
        bus_drv      = head[DATA_W-1:0];
      end
      S_WRITE: begin
        state_nxt   = S_ADV;
        ctrl_out[8] = 1'b0;
        bus_oe      = 1'b1;
        bus_drv     = head[DATA_W-1:0];
      end
      S_ADV:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader with a write-level reference model.
module tb_ram_loader;

  localparam logic [14:0] IDLE_C = 15'h0FE3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        prog_en = 1'b1;
  logic        byte_valid = 1'b0;
  logic        cmd_addr = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  wire  [7:0]  bus;
  logic [14:0] ctrl_out;
  logic [3:0]  wr_addr;
  logic        busy, fifo_full, overflow, done;

  int total = 0;
  int bad = 0;
  int ptr_m = 0;
  int exp_done = 0;
  int done_seen = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  mar_v, dat_v;
  logic [11:0] e;

  always #5 clk = ~clk;

  ram_loader #(.DATA_W(8), .ADDR_W(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .prog_en(prog_en), .byte_in(byte_in),
    .byte_valid(byte_valid), .cmd_addr(cmd_addr), .bus(bus),
    .ctrl_out(ctrl_out), .wr_addr(wr_addr), .busy(busy),
    .fifo_full(fifo_full), .overflow(overflow), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rel(input string nm);
    total++;
    if (!($isunknown(bus) || bus == 8'h00)) begin
      bad++;
      $display("FAIL %s: bus driven with %0h expected released", nm, bus);
    end
  endtask

  // Reference model: each data entry becomes one RAM write at the current pointer.
  task automatic model_push(input logic is_addr, input logic [7:0] d);
    if (is_addr) ptr_m = int'(d[3:0]);
    else begin
      exp_q.push_back({4'(ptr_m), d});
      if (ptr_m == 15) exp_done++;
      ptr_m = (ptr_m + 1) % 16;
    end
  endtask

  task automatic strobe(input logic is_addr, input logic [7:0] d, input bit accepted);
    @(negedge clk);
    byte_in = d;
    cmd_addr = is_addr;
    byte_valid = 1'b1;
    if (accepted) model_push(is_addr, d);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({nm, "_timeout"}, 32'd1, 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: observe RAM write sequences on the bus and pop the scoreboard.
  always @(negedge clk) begin
    if (resetn && prog_en) begin
      if (done) done_seen++;
      if (ctrl_out != IDLE_C)
        chk("one_strobe", 32'(ctrl_out == (IDLE_C & ~15'h0800) ||
                              ctrl_out == (IDLE_C & ~15'h0400) ||
                              ctrl_out == (IDLE_C & ~15'h0100)), 32'd1);
      if (!ctrl_out[11]) mar_v = bus;
      if (!ctrl_out[10]) dat_v = bus;
      if (!ctrl_out[8]) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(mar_v), {24'h0, 4'h0, e[11:8]});
          chk("write_data", 32'(bus), {24'h0, e[7:0]});
          chk("mar_data", 32'(dat_v), {24'h0, e[7:0]});
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dv [8];
    bit ok;

    // Reset applied with the FIFO holding an entry.
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    strobe(1'b0, 8'h3C, 1'b0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'(ctrl_out), 32'h0FE3);
    chk_rel("rst_bus");
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    ptr_m = 0;

    // Single write.
    strobe(1'b0, 8'hA5, 1'b1);
    wait_idle("single");
    chk("single_wr_addr", 32'(wr_addr), 32'd1);

    // Pointer load then four writes wrapping at the top address.
    strobe(1'b1, 8'h0C, 1'b1);
    strobe(1'b0, 8'h11, 1'b1);
    strobe(1'b0, 8'h22, 1'b1);
    strobe(1'b0, 8'h33, 1'b1);
    strobe(1'b0, 8'h44, 1'b1);
    wait_idle("ptr_load");
    chk("ptr_wr_addr", 32'(wr_addr), 32'd0);
    chk("ptr_done_count", 32'(done_seen), 32'd1);
    chk("ptr_overflow", 32'(overflow), 32'd0);

    // Six back-to-back strobes: the sixth lands on a full FIFO with a pop.
    for (int i = 0; i < 6; i++) begin
      strobe(1'b0, 8'($urandom), 1'b1);
      if (i == 4) chk("full_reached", 32'(fifo_full), 32'd1);
    end
    wait_idle("full_pop");
    chk("full_pop_overflow", 32'(overflow), 32'd0);

    // Eight back-to-back strobes: the last two hit a full FIFO with no pop.
    for (int i = 0; i < 8; i++) dv[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) strobe(1'b0, dv[i], i < 6);
    wait_idle("overflow");
    chk("overflow_set", 32'(overflow), 32'd1);

    // Strobe held high for several cycles pushes once.
    @(negedge clk);
    byte_in = 8'h5E;
    cmd_addr = 1'b0;
    byte_valid = 1'b1;
    model_push(1'b0, 8'h5E);
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    wait_idle("held_high");
    chk("held_wr_addr", 32'(wr_addr), 32'(ptr_m));
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Abort during DATA.
    strobe(1'b0, 8'hE7, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ctrl_out[10]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_reach_data", 32'(ok), 32'd1);
    chk("abort_bus_before", 32'(bus), 32'hE7);
    prog_en = 1'b0;
    #1;
    chk_rel("abort_bus_release");
    @(posedge clk);
    #1;
    chk("abort_ctrl", 32'(ctrl_out), 32'h0FE3);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    chk("abort_wr_addr", 32'(wr_addr), 32'd0);
    ptr_m = 0;
    @(negedge clk);
    prog_en = 1'b1;

    // Randomized traffic with flow control on fifo_full.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (!fifo_full) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) chk("rand_full_timeout", 32'd1, 32'd0);
      strobe($urandom_range(0, 4) == 0, 8'($urandom), 1'b1);
    end
    wait_idle("random");
    chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_done_count", 32'(done_seen), 32'(exp_done));
    chk("rand_wr_addr", 32'(wr_addr), 32'(ptr_m));
    chk("rand_overflow", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
